// File: rtl/serial_comparator_n_pkg.sv
//------------------------------------------------------------------------------
// serial_comparator_n_pkg : FSM state and result encodings for the comparator
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_comparator_n_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_GT = 2'd1,
      RES_LT = 2'd2
   } result_t;

endpackage

`default_nettype wire

// File: rtl/serial_comparator_n_digit.sv
//------------------------------------------------------------------------------
// comparator_digit : combinational unsigned compare of one DIGIT-bit slice
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module comparator_digit #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             gt,
   output logic             lt
);

   assign gt = (a > b);
   assign lt = (a < b);

endmodule

`default_nettype wire

// File: rtl/serial_comparator_n.sv
//------------------------------------------------------------------------------
// serial_comparator_n : digit-serial magnitude comparator, MSB digit first
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_comparator_n
   import serial_comparator_n_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int DIGIT      = 2,
   parameter  int EARLY_EXIT = 1,
   localparam int NDIG       = WIDTH / DIGIT,
   localparam int CW         = $clog2(NDIG) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signedMode,
   output logic             outValid,
   input  logic             outReady,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CW-1:0]    cycles
);

   localparam logic [CW-1:0] C_LAST_DIG = CW'(NDIG - 1);

   state_t           r_state;
   result_t          r_res;
   logic [WIDTH-1:0] r_opA;
   logic [WIDTH-1:0] r_opB;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_cycles;
   logic             r_inReady;
   logic             r_outValid;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic             w_digGt;
   logic             w_digLt;
   logic             w_lastDig;
   logic             w_stop;

   comparator_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a  (r_opA[WIDTH-1 -: DIGIT]),
      .b  (r_opB[WIDTH-1 -: DIGIT]),
      .gt (w_digGt),
      .lt (w_digLt)
   );

   assign w_lastDig = (r_cnt == C_LAST_DIG);
   assign w_stop    = w_lastDig || ((EARLY_EXIT != 0) && (w_digGt || w_digLt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_res      <= RES_EQ;
         r_opA      <= '0;
         r_opB      <= '0;
         r_cnt      <= '0;
         r_cycles   <= '0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_gt       <= 1'b0;
         r_eq       <= 1'b0;
         r_lt       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (inValid && r_inReady) begin
                  // Flipping the sign bits maps two's complement onto unsigned order.
                  r_opA     <= {a[WIDTH-1] ^ signedMode, a[WIDTH-2:0]};
                  r_opB     <= {b[WIDTH-1] ^ signedMode, b[WIDTH-2:0]};
                  r_cnt     <= '0;
                  r_res     <= RES_EQ;
                  r_inReady <= 1'b0;
                  r_state   <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               r_opA <= r_opA << DIGIT;
               r_opB <= r_opB << DIGIT;
               r_cnt <= r_cnt + CW'(1);
               if (r_res == RES_EQ) begin
                  if (w_digGt)      r_res <= RES_GT;
                  else if (w_digLt) r_res <= RES_LT;
               end
               if (w_stop) r_state <= ST_DONE;
            end
            ST_DONE: begin
               // First DONE cycle presents the result; r_cnt already equals digits examined.
               if (!r_outValid) begin
                  r_outValid <= 1'b1;
                  r_gt       <= (r_res == RES_GT);
                  r_eq       <= (r_res == RES_EQ);
                  r_lt       <= (r_res == RES_LT);
                  r_cycles   <= r_cnt;
               end else if (outReady) begin
                  r_outValid <= 1'b0;
                  r_gt       <= 1'b0;
                  r_eq       <= 1'b0;
                  r_lt       <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_inReady <= 1'b1;
            end
         endcase
      end
   end

   assign inReady  = r_inReady;
   assign outValid = r_outValid;
   assign gt       = r_gt;
   assign eq       = r_eq;
   assign lt       = r_lt;
   assign cycles   = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_serial_comparator_n.sv
//------------------------------------------------------------------------------
// tb_serial_comparator_n : randomized self-checking bench, both exit modes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_comparator_n;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       useConst = 1'b0;
   logic       inValid = 1'b0;
   logic       outReady = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       signedMode = 1'b0;

   logic       inReadyE, outValidE, gtE, eqE, ltE;
   logic       inReadyC, outValidC, gtC, eqC, ltC;
   logic [2:0] cyclesE, cyclesC;

   logic       inReadyM, outValidM, gtM, eqM, ltM;
   logic [2:0] cyclesM;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   serial_comparator_n #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dutE (
      .clk(clk), .rst_n(rst_n),
      .inValid(inValid & ~useConst), .inReady(inReadyE),
      .a(a), .b(b), .signedMode(signedMode),
      .outValid(outValidE), .outReady(outReady & ~useConst),
      .gt(gtE), .eq(eqE), .lt(ltE), .cycles(cyclesE)
   );

   serial_comparator_n #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dutC (
      .clk(clk), .rst_n(rst_n),
      .inValid(inValid & useConst), .inReady(inReadyC),
      .a(a), .b(b), .signedMode(signedMode),
      .outValid(outValidC), .outReady(outReady & useConst),
      .gt(gtC), .eq(eqC), .lt(ltC), .cycles(cyclesC)
   );

   assign inReadyM  = useConst ? inReadyC  : inReadyE;
   assign outValidM = useConst ? outValidC : outValidE;
   assign gtM       = useConst ? gtC       : gtE;
   assign eqM       = useConst ? eqC       : eqE;
   assign ltM       = useConst ? ltC       : ltE;
   assign cyclesM   = useConst ? cyclesC   : cyclesE;

   task automatic check(input string tag, input int got, input int exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: 0 = EQ, 1 = GT, 2 = LT; k = digits examined.
   task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic sm,
                        input logic ee, output int res, output int k);
      int va, vb, firstDiff;
      va = sm ? int'($signed(ma)) : int'(ma);
      vb = sm ? int'($signed(mb)) : int'(mb);
      res = (va > vb) ? 1 : (va < vb) ? 2 : 0;
      firstDiff = 0;
      for (int i = 0; i < 4; i++) begin
         if (firstDiff == 0 && ((ma >> (6 - 2*i)) & 8'd3) != ((mb >> (6 - 2*i)) & 8'd3))
            firstDiff = i + 1;
      end
      k = (ee && firstDiff != 0) ? firstDiff : 4;
   endtask

   task automatic checkResult(input string tag, input int res, input int k);
      check({tag, ".outValid"}, int'(outValidM), 1);
      check({tag, ".gt"}, int'(gtM), int'(res == 1));
      check({tag, ".eq"}, int'(eqM), int'(res == 0));
      check({tag, ".lt"}, int'(ltM), int'(res == 2));
      check({tag, ".cycles"}, int'(cyclesM), k);
   endtask

   task automatic doTxn(input logic [7:0] ta, input logic [7:0] tb, input logic sm, input int hold);
      int expRes, expK, lat;
      model(ta, tb, sm, ~useConst, expRes, expK);
      @(negedge clk);
      check("inReady.idle", int'(inReadyM), 1);
      a = ta; b = tb; signedMode = sm; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); signedMode = 1'($urandom);
      lat = 0;
      while (!outValidM && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, expK + 1);
      checkResult("result", expRes, expK);
      for (int i = 0; i < hold; i++) begin
         inValid = 1'b1; a = 8'h00; outReady = 1'b0;
         @(posedge clk); #1;
         check("hold.inReady", int'(inReadyM), 0);
         checkResult("hold", expRes, expK);
      end
      inValid = 1'b0; outReady = 1'b1;
      @(posedge clk); #1;
      outReady = 1'b0;
      check("xfer.outValid", int'(outValidM), 0);
      check("xfer.flags", int'({gtM, eqM, ltM}), 0);
      check("xfer.cyclesHeld", int'(cyclesM), expK);
      check("xfer.inReady", int'(inReadyM), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst.outValid", int'(outValidE), 0);
      check("rst.flags", int'({gtE, eqE, ltE}), 0);
      check("rst.cycles", int'(cyclesE), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst.inReady", int'(inReadyE), 1);

      // Directed cases, early-exit instance
      doTxn(8'hC3, 8'h43, 1'b0, 0);
      doTxn(8'h5A, 8'h5A, 1'b0, 2);
      doTxn(8'h80, 8'h01, 1'b1, 0);
      doTxn(8'h80, 8'h01, 1'b0, 5);

      // Reset in the second compare cycle discards the operation
      @(negedge clk);
      a = 8'h5A; b = 8'h5A; signedMode = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midRst.outValid", int'(outValidE), 0);
      check("midRst.flags", int'({gtE, eqE, ltE}), 0);
      check("midRst.cycles", int'(cyclesE), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("midRst.noResult", int'(outValidE), 0);
         check("midRst.inReady", int'(inReadyE), 1);
      end

      // Randomized, early-exit instance
      for (int i = 0; i < 40; i++)
         doTxn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      for (int i = 0; i < 10; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         doTxn(v, v ^ (8'h01 << $urandom_range(0, 7)), 1'($urandom), 0);
      end

      // Constant-latency instance
      useConst = 1'b1;
      doTxn(8'hC3, 8'h43, 1'b0, 1);
      doTxn(8'h80, 8'h01, 1'b1, 0);
      for (int i = 0; i < 30; i++)
         doTxn(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_comparator_n.md
SERIAL_COMPARATOR_N -- requirements
Module: serial_comparator_n

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be ≥2.
REQ-002 Parameter DIGIT, default 2, bits examined per compare cycle; SHALL divide WIDTH exactly; NDIG = WIDTH/DIGIT.
REQ-003 Parameter EARLY_EXIT, default 1: 1 = stop at first differing digit; 0 = always run NDIG cycles (constant latency).
REQ-004 CLK  in  1  single clock, rising-edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 IN_VALID  in  1  operand pair offered.
REQ-007 IN_READY  out  1  block can accept operands.
REQ-008 A  in  WIDTH  operand A.
REQ-009 B  in  WIDTH  operand B.
REQ-010 SIGNED_MODE  in  1  1 = two's-complement compare; sampled with operands.
REQ-011 OUT_VALID  out  1  result available.
REQ-012 OUT_READY  in  1  consumer takes result.
REQ-013 GT / EQ / LT  out  1 each  A>B / A==B / A<B.
REQ-014 CYCLES  out  clog2(NDIG)+1  number of digits examined for this result.

Function
REQ-015 FSM states SHALL be IDLE, COMPARE, DONE; IN_READY=1 only in IDLE.
REQ-016 IDLE: on IN_VALID&IN_READY at an edge, SHALL latch A, B, SIGNED_MODE, clear digit counter, go to COMPARE.
REQ-017 COMPARE: each cycle SHALL compare the current DIGIT-bit slice, MSB digit first, then shift both operand registers left by DIGIT.
REQ-018 Signed mode: sign bit of both operands SHALL be inverted before the first-digit compare; other bits unchanged.
REQ-019 First differing digit SHALL fix the result (GT or LT); later digits SHALL NOT change it.
REQ-020 EARLY_EXIT=1: go to DONE at the edge ending the first differing digit, or after digit NDIG; EARLY_EXIT=0: go to DONE only after digit NDIG.
REQ-021 No differing digit after NDIG digits SHALL yield EQ.
REQ-022 Latency: OUT_VALID rises k+1 cycles after the accepting edge, k = CYCLES (1..NDIG).
REQ-023 DONE: OUT_VALID=1; exactly one of GT/EQ/LT =1; outputs and CYCLES SHALL hold stable until OUT_VALID&OUT_READY, then return to IDLE.
REQ-024 OUT_VALID=0 SHALL force GT=EQ=LT=0; CYCLES holds last value.
REQ-025 IN_VALID outside IDLE SHALL be ignored; no operand capture.
REQ-026 OUT_READY high in the cycle OUT_VALID rises SHALL complete the transfer in that cycle; new accept no earlier than the following cycle.
REQ-027 Operand registers SHALL NOT toggle in IDLE or DONE (low-power hold).

Reset
REQ-028 RST_N low SHALL immediately force IDLE, IN_READY=1 (after release), OUT_VALID=0, GT=EQ=LT=0, CYCLES=0, operand registers 0.
REQ-029 Reset during COMPARE or DONE SHALL discard the operation; no result is emitted.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding and the result encoding (GT/EQ/LT) constants.
REQ-031 Sub-module comparator_digit SHALL be the combinational DIGIT-bit slice compare (outputs gt, lt), instantiated once.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-032 Unsigned A=0xC3, B=0x43 -> GT=1, CYCLES=1, OUT_VALID 2 cycles after accept.
REQ-033 A=B=0x5A -> EQ=1, CYCLES=4, OUT_VALID 5 cycles after accept.
REQ-034 A=0x80, B=0x01: SIGNED_MODE=1 -> LT, CYCLES=1; SIGNED_MODE=0 -> GT, CYCLES=1.
REQ-035 OUT_READY=0 for 5 cycles in DONE with IN_VALID=1, A=0x00 -> GT/EQ/LT/CYCLES stable, IN_READY=0, operands not captured.
REQ-036 RST_N low in 2nd COMPARE cycle of A=0x5A, B=0x5A -> all outputs 0 at once, no OUT_VALID, IN_READY=1 after release.
REQ-037 EARLY_EXIT=0, A=0xC3, B=0x43 -> GT=1, CYCLES=4.
